// File: rtl/vector_lane_engine_pkg.sv
// vector_lane_engine_pkg: shared encodings, FSM states and element-width helper
// for the vector lane engine and its lane ALU.
package vector_lane_engine_pkg;
  typedef enum logic [2:0] {SEW8 = 3'd0, SEW16 = 3'd1, SEW32 = 3'd2, SEW64 = 3'd3} sew_e;
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_RSUB = 4'd2,  OP_AND = 4'd3,
    OP_OR   = 4'd4,  OP_XOR  = 4'd5,  OP_MINU = 4'd6,  OP_MIN = 4'd7,
    OP_MAXU = 4'd8,  OP_MAX  = 4'd9,  OP_SLL  = 4'd10, OP_SRL = 4'd11,
    OP_SRA  = 4'd12
  } op_e;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;
  localparam logic VLE_ERR_NONE    = 1'b0;
  localparam logic VLE_ERR_ILLEGAL = 1'b1;
  function automatic logic [63:0] sew_mask(input logic [1:0] s);
    return ~(~64'(0) << (7'd8 << s));
  endfunction
endpackage

// File: rtl/vector_lane_alu.sv
// vector_lane_alu: one element operation at 8/16/32/64-bit width; result
// zero-extended to 64 bits.
module vector_lane_alu
  import vector_lane_engine_pkg::*;
(
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic [1:0]  sew_i,
  input  logic [3:0]  op_i,
  output logic [63:0] y_o
);
  logic [63:0] m, am, bm, as, bs, r;
  logic [5:0] sh;
  logic lt_u, lt_s;
  assign m = sew_mask(sew_i);
  assign am = a_i & m;
  assign bm = b_i & m;
  // sign-extend each operand from its element width to 64 bits
  assign as = |(am & ~(m >> 1)) ? am | ~m : am;
  assign bs = |(bm & ~(m >> 1)) ? bm | ~m : bm;
  assign sh = a_i[5:0] & {sew_i == 2'd3, sew_i[1], |sew_i, 3'b111};
  assign lt_u = am < bm;
  assign lt_s = $signed(as) < $signed(bs);
  always_comb begin
    case (op_i)
      OP_ADD:  r = am + bm;
      OP_SUB:  r = bm - am;
      OP_RSUB: r = am - bm;
      OP_AND:  r = am & bm;
      OP_OR:   r = am | bm;
      OP_XOR:  r = am ^ bm;
      OP_MINU: r = lt_u ? am : bm;
      OP_MIN:  r = lt_s ? am : bm;
      OP_MAXU: r = lt_u ? bm : am;
      OP_MAX:  r = lt_s ? bm : am;
      OP_SLL:  r = bm << sh;
      OP_SRL:  r = bm >> sh;
      OP_SRA:  r = 64'($signed(bs) >>> sh);
      default: r = '0;
    endcase
  end
  assign y_o = r & m;
endmodule

// File: rtl/vector_lane_engine.sv
// vector_lane_engine: multi-lane elementwise vector integer unit with masked,
// tail-undisturbed writeback. Define VLE_TAIL_AGNOSTIC_EN to fill tails with ones.
module vector_lane_engine
  import vector_lane_engine_pkg::*;
#(
  parameter int VLEN  = 256,
  parameter int LANES = 4,
  parameter int VL_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy_in,
  input  logic              start,
  output logic              ready,
  input  logic [2:0]        sew,
  input  logic [VL_W-1:0]   vl,
  input  logic              vm,
  input  logic [3:0]        op,
  input  logic              use_scalar,
  input  logic [63:0]       scalar,
  input  logic [VLEN-1:0]   vs1,
  input  logic [VLEN-1:0]   vs2,
  input  logic [VLEN-1:0]   vd_old,
  input  logic [VLEN/8-1:0] mask,
  output logic [VLEN-1:0]   result,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int NE = VLEN / 8;
  localparam int SW = VL_W + 3;
  state_e state_q;
  logic [1:0] sew_q;
  logic [3:0] op_q;
  logic [VL_W-1:0] vl_q, idx_q, vlmax, vl_eff;
  logic vm_q, use_scalar_q, done_q, err_q, acc, acc_err;
  logic [63:0] scalar_q;
  logic [VLEN-1:0] vs1_q, vs2_q, result_q, result_d, acc_val;
  logic [NE-1:0] mask_q;
  logic [VL_W-1:0] e_w [LANES];
  logic [SW-1:0] sh_w [LANES];
  logic [63:0] a_w [LANES];
  logic [63:0] b_w [LANES];
  logic [63:0] y_w [LANES];
  logic [LANES-1:0] we_w;
  assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy = state_q == S_RUN;
  assign done = done_q;
  assign err = err_q;
  assign result = result_q;
  assign acc = start && ready;
  assign acc_err = sew[2] || (op > OP_SRA);
  assign vlmax = VL_W'(NE) >> sew[1:0];
  assign vl_eff = (vl < vlmax) ? vl : vlmax;
`ifdef VLE_TAIL_AGNOSTIC_EN
  logic [SW-1:0] tail_sh;
  assign tail_sh = {vl_eff, 3'b000} << sew[1:0];
  assign acc_val = acc_err ? vd_old : vd_old | (~VLEN'(0) << tail_sh);
`else
  assign acc_val = vd_old;
`endif
  // each lane slices its element straight out of the latched source vectors
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign e_w[k] = idx_q + VL_W'(k);
    assign sh_w[k] = {e_w[k], 3'b000} << sew_q;
    assign b_w[k] = 64'(vs2_q >> sh_w[k]);
    assign a_w[k] = use_scalar_q ? scalar_q : 64'(vs1_q >> sh_w[k]);
    assign we_w[k] = (e_w[k] < vl_q) && (vm_q || |(mask_q & (NE'(1) << e_w[k])));
    vector_lane_alu u_alu (
      .a_i  (a_w[k]),
      .b_i  (b_w[k]),
      .sew_i(sew_q),
      .op_i (op_q),
      .y_o  (y_w[k])
    );
  end
  always_comb begin
    result_d = result_q;
    for (int k = 0; k < LANES; k++)
      result_d = we_w[k] ? (result_d & ~(VLEN'(sew_mask(sew_q)) << sh_w[k])) | (VLEN'(y_w[k]) << sh_w[k]) : result_d;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      result_q <= '0;
      done_q <= 1'b0;
      err_q <= VLE_ERR_NONE;
      idx_q <= '0;
    end else if (rdy_in) begin
      done_q <= 1'b0;
      if (acc) begin
        sew_q <= sew[1:0];
        op_q <= op;
        vl_q <= vl_eff;
        vm_q <= vm;
        use_scalar_q <= use_scalar;
        scalar_q <= scalar;
        vs1_q <= vs1;
        vs2_q <= vs2;
        mask_q <= mask;
        result_q <= acc_val;
        idx_q <= '0;
        err_q <= acc_err ? VLE_ERR_ILLEGAL : VLE_ERR_NONE;
        state_q <= (acc_err || vl_eff == '0) ? S_DONE : S_RUN;
        done_q <= acc_err || vl_eff == '0;
      end else if (state_q == S_RUN) begin
        result_q <= result_d;
        idx_q <= idx_q + VL_W'(LANES);
        if (idx_q + VL_W'(LANES) >= vl_q) begin
          state_q <= S_DONE;
          done_q <= 1'b1;
        end
      end else if (state_q == S_DONE) begin
        state_q <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_vector_lane_engine.sv
// tb_vector_lane_engine: directed and randomized checks of vector_lane_engine
// against an element-level arithmetic model (VLEN=256, LANES=4).
module tb_vector_lane_engine;
  logic clk = 1'b0, rst, rdy_in, start, ready, busy, done, err;
  logic [2:0] sew;
  logic [8:0] vl;
  logic vm, use_scalar;
  logic [3:0] op;
  logic [63:0] scalar;
  logic [255:0] vs1, vs2, vd_old, result;
  logic [31:0] mask;
  int n_vec = 0, n_err = 0;

  vector_lane_engine #(.VLEN(256), .LANES(4), .VL_W(9)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in), .start(start), .ready(ready),
    .sew(sew), .vl(vl), .vm(vm), .op(op), .use_scalar(use_scalar),
    .scalar(scalar), .vs1(vs1), .vs2(vs2), .vd_old(vd_old), .mask(mask),
    .result(result), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rvec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [255:0] model(input int s, input int l, input bit m_vm, input int o,
      input bit us, input logic [63:0] sc, input logic [255:0] v1, input logic [255:0] v2,
      input logic [255:0] vd, input logic [31:0] mk);
    logic [255:0] r;
    int w, n, sh;
    longint unsigned m, a, b, y;
    longint sa, sb;
    r = vd;
    if (s > 3 || o > 12) return vd;
    w = 8 << s;
    n = (l < 256 / w) ? l : 256 / w;
    m = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
    for (int i = 0; i < 256 / w; i++) begin
      if (i >= n) begin
`ifdef VLE_TAIL_AGNOSTIC_EN
        for (int j = 0; j < w; j++) r[i*w + j] = 1'b1;
`endif
        continue;
      end
      if (!m_vm && !mk[i]) continue;
      a = (us ? sc : 64'(v1 >> (i * w))) & m;
      b = 64'(v2 >> (i * w)) & m;
      sa = $signed(a << (64 - w)) >>> (64 - w);
      sb = $signed(b << (64 - w)) >>> (64 - w);
      sh = int'(a % longint'(w));
      case (o)
        0: y = a + b;
        1: y = b - a;
        2: y = a - b;
        3: y = a & b;
        4: y = a | b;
        5: y = a ^ b;
        6: y = (a < b) ? a : b;
        7: y = (sa < sb) ? a : b;
        8: y = (a > b) ? a : b;
        9: y = (sa > sb) ? a : b;
        10: y = b << sh;
        11: y = b >> sh;
        default: y = 64'(sb >>> sh);
      endcase
      y &= m;
      for (int j = 0; j < w; j++) r[i*w + j] = y[j];
    end
    return r;
  endfunction

  function automatic int explat(input int s, input int l, input int o);
    int n;
    if (s > 3 || o > 12) return 0;
    n = (l < (32 >> s)) ? l : (32 >> s);
    return (n + 3) / 4;
  endfunction

  task automatic run_op(input logic [2:0] s, input logic [8:0] l, input bit m_vm, input logic [3:0] o,
      input bit us, input logic [63:0] sc, input logic [255:0] v1, input logic [255:0] v2,
      input logic [255:0] vd, input logic [31:0] mk, output int lat, output int nbusy);
    sew = s; vl = l; vm = m_vm; op = o; use_scalar = us; scalar = sc;
    vs1 = v1; vs2 = v2; vd_old = vd; mask = mk; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 0; nbusy = 0;
    while (!done && lat < 200) begin
      nbusy += int'(busy);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
    n_vec++; if (result !== 256'd0) begin n_err++; $display("FAIL reset_result: got %h want 0", result); end
    rst = 1'b1;
  endtask

  task automatic test_add();
    logic [255:0] v1, v2, vd, exp;
    int lat, nb;
    vd = rvec(); v1 = '0; v2 = '0;
    for (int i = 0; i < 8; i++) begin v1[i*32 +: 32] = i; v2[i*32 +: 32] = 100; end
    exp = model(2, 8, 1'b1, 0, 1'b0, 64'd0, v1, v2, vd, 32'd0);
    run_op(3'd2, 9'd8, 1'b1, 4'd0, 1'b0, 64'd0, v1, v2, vd, 32'd0, lat, nb);
    n_vec++; if (result !== exp) begin n_err++; $display("FAIL add_result: got %h want %h", result, exp); end
    n_vec++; if (result[224 +: 32] !== 32'd107) begin n_err++; $display("FAIL add_elem7: got %0d want 107", result[224 +: 32]); end
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL add_latency: got %0d want 2", lat); end
    n_vec++; if (nb !== 2) begin n_err++; $display("FAIL add_busy_cycles: got %0d want 2", nb); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL add_err: got %b want 0", err); end
  endtask

  task automatic test_mask_sub();
    logic [255:0] v1, v2, vd, exp;
    logic [7:0] tail;
    int lat, nb;
    vd = {32{8'hAA}}; v1 = rvec(); v2 = rvec();
`ifdef VLE_TAIL_AGNOSTIC_EN
    tail = 8'hFF;
`else
    tail = 8'hAA;
`endif
    exp = model(0, 5, 1'b0, 1, 1'b0, 64'd0, v1, v2, vd, 32'b10101);
    run_op(3'd0, 9'd5, 1'b0, 4'd1, 1'b0, 64'd0, v1, v2, vd, 32'b10101, lat, nb);
    n_vec++; if (result !== exp) begin n_err++; $display("FAIL mask_result: got %h want %h", result, exp); end
    n_vec++; if (result[7:0] !== 8'(v2[7:0] - v1[7:0])) begin n_err++; $display("FAIL mask_elem0: got %h want %h", result[7:0], 8'(v2[7:0] - v1[7:0])); end
    n_vec++; if (result[15:8] !== 8'hAA) begin n_err++; $display("FAIL mask_elem1: got %h want aa", result[15:8]); end
    n_vec++; if (result[255:248] !== tail) begin n_err++; $display("FAIL mask_tail: got %h want %h", result[255:248], tail); end
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL mask_latency: got %0d want 2", lat); end
  endtask

  task automatic test_min_sra();
    logic [255:0] v1, v2, vd, exp;
    int lat, nb;
    vd = rvec(); v1 = rvec(); v2 = rvec();
    v1[15:0] = 16'h8000; v2[15:0] = 16'h0001;
    exp = model(1, 1, 1'b1, 7, 1'b0, 64'd0, v1, v2, vd, 32'd0);
    run_op(3'd1, 9'd1, 1'b1, 4'd7, 1'b0, 64'd0, v1, v2, vd, 32'd0, lat, nb);
    n_vec++; if (result[15:0] !== 16'h8000) begin n_err++; $display("FAIL min_signed: got %h want 8000", result[15:0]); end
    n_vec++; if (result !== exp) begin n_err++; $display("FAIL min_result: got %h want %h", result, exp); end
    run_op(3'd1, 9'd1, 1'b1, 4'd6, 1'b0, 64'd0, v1, v2, vd, 32'd0, lat, nb);
    n_vec++; if (result[15:0] !== 16'h0001) begin n_err++; $display("FAIL minu: got %h want 0001", result[15:0]); end
    v2[15:0] = 16'h8000;
    exp = model(1, 1, 1'b1, 12, 1'b1, 64'd15, v1, v2, vd, 32'd0);
    run_op(3'd1, 9'd1, 1'b1, 4'd12, 1'b1, 64'd15, v1, v2, vd, 32'd0, lat, nb);
    n_vec++; if (result[15:0] !== 16'hFFFF) begin n_err++; $display("FAIL sra: got %h want ffff", result[15:0]); end
    n_vec++; if (result !== exp) begin n_err++; $display("FAIL sra_result: got %h want %h", result, exp); end
  endtask

  task automatic test_err_vl0();
    logic [255:0] vd;
    int lat, nb;
    vd = rvec();
    run_op(3'd2, 9'd0, 1'b1, 4'd0, 1'b0, 64'd0, rvec(), rvec(), vd, 32'd0, lat, nb);
    n_vec++; if (lat !== 0) begin n_err++; $display("FAIL vl0_latency: got %0d want 0", lat); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL vl0_err: got %b want 0", err); end
`ifndef VLE_TAIL_AGNOSTIC_EN
    n_vec++; if (result !== vd) begin n_err++; $display("FAIL vl0_result: got %h want %h", result, vd); end
`endif
    vd = rvec();
    run_op(3'b100, 9'd8, 1'b1, 4'd0, 1'b0, 64'd0, rvec(), rvec(), vd, 32'd0, lat, nb);
    n_vec++; if (lat !== 0) begin n_err++; $display("FAIL badsew_latency: got %0d want 0", lat); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL badsew_err: got %b want 1", err); end
    n_vec++; if (result !== vd) begin n_err++; $display("FAIL badsew_result: got %h want %h", result, vd); end
    run_op(3'd0, 9'd8, 1'b1, 4'd13, 1'b0, 64'd0, rvec(), rvec(), vd, 32'd0, lat, nb);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL badop_err: got %b want 1", err); end
  endtask

  task automatic test_freeze_reset();
    logic [255:0] v1, v2, vd, exp, snap;
    int lat, nb;
    v1 = rvec(); v2 = rvec(); vd = rvec();
    exp = model(0, 16, 1'b1, 0, 1'b0, 64'd0, v1, v2, vd, 32'd0);
    sew = 3'd0; vl = 9'd16; vm = 1'b1; op = 4'd0; use_scalar = 1'b0;
    vs1 = v1; vs2 = v2; vd_old = vd; mask = '0; start = 1'b1;
    @(posedge clk); #1;
    vs1 = rvec(); op = 4'd5;
    @(posedge clk); #1;
    start = 1'b0; snap = result; rdy_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (result !== snap) begin n_err++; $display("FAIL freeze_result: got %h want %h", result, snap); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL freeze_busy: got %b want 1", busy); end
    rdy_in = 1'b1; lat = 4;
    while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
    n_vec++; if (lat !== 7) begin n_err++; $display("FAIL freeze_latency: got %0d want 7", lat); end
    n_vec++; if (result !== exp) begin n_err++; $display("FAIL freeze_final: got %h want %h", result, exp); end
    vs1 = v1; op = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_vec++; if (busy !== 1'b0 || ready !== 1'b1) begin n_err++; $display("FAIL midrun_reset_state: got busy=%b ready=%b want busy=0 ready=1", busy, ready); end
    n_vec++; if (result !== 256'd0) begin n_err++; $display("FAIL midrun_reset_result: got %h want 0", result); end
    lat = 0; nb = 0;
  endtask

  task automatic test_back_to_back();
    logic [255:0] v1, v2, vd, exp;
    int lat, nb;
    v1 = rvec(); v2 = rvec(); vd = rvec();
    exp = model(2, 8, 1'b1, 0, 1'b0, 64'd0, v1, v2, vd, 32'd0);
    run_op(3'd2, 9'd8, 1'b1, 4'd0, 1'b0, 64'd0, v1, v2, vd, 32'd0, lat, nb);
    n_vec++; if (result !== exp) begin n_err++; $display("FAIL b2b_first: got %h want %h", result, exp); end
    v1 = rvec(); v2 = rvec(); vd = rvec();
    exp = model(3, 40, 1'b1, 5, 1'b0, 64'd0, v1, v2, vd, 32'd0);
    sew = 3'd3; vl = 9'd40; op = 4'd5; vs1 = v1; vs2 = v2; vd_old = vd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++; if (done !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got done=%b busy=%b want done=0 busy=1", done, busy); end
    lat = 0;
    while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL b2b_clamp_latency: got %0d want 1", lat); end
    n_vec++; if (result !== exp) begin n_err++; $display("FAIL b2b_second: got %h want %h", result, exp); end
    @(posedge clk); #1;
    n_vec++; if (done !== 1'b0 || ready !== 1'b1) begin n_err++; $display("FAIL b2b_done_pulse: got done=%b ready=%b want done=0 ready=1", done, ready); end
    n_vec++; if (result !== exp) begin n_err++; $display("FAIL b2b_hold: got %h want %h", result, exp); end
  endtask

  task automatic test_random();
    logic [255:0] v1, v2, vd, exp;
    logic [63:0] sc;
    logic [31:0] mk;
    logic [2:0] s;
    logic [3:0] o;
    logic [8:0] l;
    bit m_vm, us, ee;
    int lat, nb;
    for (int t = 0; t < 40; t++) begin
      s = 3'($urandom_range(0, 4));
      if (s == 3'd4) s = 3'($urandom_range(4, 7));
      o = 4'($urandom_range(0, 14));
      l = 9'($urandom_range(0, 40));
      m_vm = 1'($urandom); us = 1'($urandom);
      sc = {$urandom, $urandom}; mk = $urandom;
      v1 = rvec(); v2 = rvec(); vd = rvec();
      exp = model(int'(s), int'(l), m_vm, int'(o), us, sc, v1, v2, vd, mk);
      ee = (s > 3'd3) || (o > 4'd12);
      run_op(s, l, m_vm, o, us, sc, v1, v2, vd, mk, lat, nb);
      n_vec++; if (result !== exp) begin n_err++; $display("FAIL rand%0d_result sew=%0d op=%0d vl=%0d: got %h want %h", t, s, o, l, result, exp); end
      n_vec++; if (err !== ee) begin n_err++; $display("FAIL rand%0d_err: got %b want %b", t, err, ee); end
      n_vec++; if (lat !== explat(int'(s), int'(l), int'(o))) begin n_err++; $display("FAIL rand%0d_latency: got %0d want %0d", t, lat, explat(int'(s), int'(l), int'(o))); end
    end
  endtask

  initial begin
    rst = 1'b0; rdy_in = 1'b1; start = 1'b0; sew = '0; vl = '0; vm = 1'b1; op = '0;
    use_scalar = 1'b0; scalar = '0; vs1 = '0; vs2 = '0; vd_old = '0; mask = '0;
    test_reset();
    test_add();
    test_mask_sub();
    test_min_sra();
    test_err_vl0();
    test_freeze_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vector_lane_engine.md
Name: vector_lane_engine

Overview:
- Parametrised multi-lane vector integer execution unit: elementwise ops over up to VLEN bits, LANES elements per cycle.
- Supports SEW 8/16/32/64, mask-undisturbed and tail-undisturbed writeback, and vector-vector or vector-scalar operand selection.
- Start/done handshake with the vector issue stage; sits between the vector register read stage and vector writeback.

Parameters:
- VLEN, 256, vector register width in bits; multiple of 64.
- LANES, 4, elements processed per cycle; power of 2, 1..VLEN/8.
- VL_W, 9, width of vl input; must hold VLEN/8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low (already decided).
- rdy_in  in  1  global enable; low freezes all state.
- start  in  1  request; accepted only when ready=1.
- ready  out  1  high in IDLE and DONE.
- sew  in  3  000=8b, 001=16b, 010=32b, 011=64b; 1xx is illegal.
- vl  in  VL_W  active element count.
- vm  in  1  1=unmasked; 0=use mask bits.
- op  in  4  0 ADD, 1 SUB, 2 RSUB, 3 AND, 4 OR, 5 XOR, 6 MINU, 7 MIN, 8 MAXU, 9 MAX, 10 SLL, 11 SRL, 12 SRA; others illegal.
- use_scalar  in  1  1=operand A is scalar, else vs1.
- scalar  in  64  scalar operand, pre-extended by the caller.
- vs1, vs2, vd_old  in  VLEN  source vectors and old destination.
- mask  in  VLEN/8  bit i governs element i (v0 layout).
- result  out  VLEN  destination value.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on completion.
- err  out  1  valid with done; illegal sew/op.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (rst=0 at posedge): state=IDLE, result=0, done=0, err=0, busy=0, internal index=0. Reset mid-operation abandons the operation.
- rdy_in=0: no state, register or output change.
- Accept: start&&ready. Latches all inputs, copies vd_old into result, idx=0, err=(sew[2]|op>12).
  - If err, or effective vl is 0 → DONE next cycle.
  - Otherwise → RUN.
- VLMAX = VLEN/(8<<sew). Effective vl = min(vl, VLMAX).
- RUN, each cycle: lane k handles element e=idx+k when e<vl.
  - Operand B = vs2[e].
  - Operand A = scalar[SEW-1:0] if use_scalar, else vs1[e].
  - Element written iff vm || mask[e]. Otherwise the vd_old value stays (mask-undisturbed).
  - idx+=LANES. When idx+LANES>=vl → DONE.
- RUN latency = ceil(vl/LANES) cycles. done is asserted in the first DONE cycle only.
- Tail elements e>=vl keep vd_old (tail-undisturbed).
- Arithmetic is modulo 2^SEW.
  - RSUB = A−B.
  - MIN/MAX are signed at SEW; MINU/MAXU are unsigned.
  - Shift amount = A[log2(SEW)-1:0]. SRA is an arithmetic shift at SEW.
- result stays stable from done until the next accept.
- DONE with start=1: accept in the same cycle, done deasserts (back-to-back). DONE with start=0 → IDLE.
- start while busy: ignored, no queueing.

Optional Feature:
- VLE_TAIL_AGNOSTIC_EN.
- Defined: tail elements (e>=effective vl) are written all-ones at accept.
- Undefined: tail elements are undisturbed (vd_old). Masked-off elements are undisturbed in both builds.

Decomposition:
- Shared header src/defines.v holds: SEW encodings, op codes, FSM state encodings, VLE_ERR constants.
- Natural sub-module: vector_lane_alu.
  - Inputs: one 64-bit element pair plus sew and op.
  - Output: SEW-wide result, zero-extended to 64.
  - Instantiated LANES times with a generate loop.
- Dispatch/writeback slicing stays in the top level.

Test Plan:
- SEW=32, VLEN=256, LANES=4, vl=8, ADD, vs1[i]=i, vs2[i]=100 → element i=100+i; busy 2 cycles; done on 3rd cycle after accept.
- SEW=8, vl=5, vm=0, mask=0b10101, SUB, vd_old=0xAA.. → elements 0,2,4 updated; 1,3 and tail 5..31 = 0xAA (tail 0xFF with VLE_TAIL_AGNOSTIC_EN).
- SEW=16, MIN vs MINU, A=0x8000, B=0x0001 → MIN=0x8000, MINU=0x0001; SRA of 0x8000 by 15 = 0xFFFF.
- vl=0 and sew=3'b100 → done one cycle after accept, result=vd_old, err=0 and 1 respectively.
- rdy_in low 3 cycles mid-RUN → idx and result frozen, total latency +3. rst=0 mid-RUN → IDLE and result=0 next edge.
- Back-to-back: start held high in DONE → new op accepted that cycle, done pulses once per op, vl=40 at SEW=64 clamps to 4.
